// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: drives the 1-cycle-latency ROM and buffers words for decode.
// Optional macro INSTR_FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module instr_fetch_unit #(
  parameter int          ADDR_W     = 11,
  parameter int          DATA_W     = 32,
  parameter int unsigned RESET_PC   = 0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clka,
  input  logic              rsta_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
  localparam logic [CNT_W:0]    DEPTH_OCC  = (CNT_W + 1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data_d [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_pc_q   [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_pc_d   [FIFO_DEPTH];
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d;

  logic             pop, push, issue;
  logic [CNT_W:0]   occupancy;
  logic [CNT_W-1:0] remaining;

  // Occupancy counts the word still in the ROM so a full FIFO can never be overrun.
  always_comb begin
    pop       = (count_q != '0) && inst_ready;
    push      = inflight_q && !redirect_valid;
    occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
    issue     = !redirect_valid && (occupancy < DEPTH_OCC);
    remaining = count_q - {{PTR_W{1'b0}}, pop};
  end

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + ADDR_W'(1);
    end
  end

  // The head is held in its own register so it keeps its last value once the FIFO drains.
  always_comb begin
    mem_data_d  = mem_data_q;
    mem_pc_d    = mem_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    head_data_d = head_data_q;
    head_pc_d   = head_pc_q;
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_data_d[wr_ptr_q] = rom_dout;
        mem_pc_d[wr_ptr_q]   = inflight_pc_q;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = remaining + {{PTR_W{1'b0}}, push};
      if (remaining != '0) begin
        head_data_d = mem_data_q[rd_ptr_d];
        head_pc_d   = mem_pc_q[rd_ptr_d];
      end else if (push) begin
        head_data_d = rom_dout;
        head_pc_d   = inflight_pc_q;
      end
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      pc_q          <= RESET_ADDR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      head_data_q   <= '0;
      head_pc_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_pc_q[i]   <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      head_data_q   <= head_data_d;
      head_pc_q     <= head_pc_d;
      mem_data_q    <= mem_data_d;
      mem_pc_q      <= mem_pc_d;
    end
  end

  assign rom_addr   = pc_q;
  assign inst_valid = (count_q != '0);
  assign inst_data  = head_data_q;
  assign inst_pc    = head_pc_q;

`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Saturating counters; redirects deliberately leave them untouched.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (push && (perf_fetched_q != 32'hFFFF_FFFF)) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (inst_ready && !inst_valid && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`else
  // Without the macro no performance counters are built.
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a 1-cycle-latency ROM model (word k = 0x1000_0000 + k).
// Define INSTR_FETCH_PERF_EN to also exercise the performance counters.
module tb_instr_fetch_unit;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  logic              clka = 1'b0;
  logic              rsta_n;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
`ifdef INSTR_FETCH_PERF_EN
  logic [31:0]       perf_fetched;
  logic [31:0]       perf_stall;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  instr_fetch_unit #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RESET_PC(0),
    .FIFO_DEPTH(2)
  ) dut (
    .clka(clka),
    .rsta_n(rsta_n),
    .rom_addr(rom_addr),
    .rom_dout(rom_dout),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_data(inst_data),
    .inst_pc(inst_pc)
`ifdef INSTR_FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall(perf_stall)
`endif
  );

  always #5 clka = ~clka;

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return 32'h1000_0000 + {{(DATA_W-ADDR_W){1'b0}}, a};
  endfunction

  // ROM: registered read, no output register.
  always @(posedge clka) rom_dout <= rom_word(rom_addr);

  task automatic do_reset();
    @(negedge clka);
    rsta_n         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    repeat (2) @(negedge clka);
    rsta_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [ADDR_W+DATA_W:0] exp_v;
    @(negedge clka);
    rsta_n         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    repeat (2) @(negedge clka);
    tests_run++;
    if (rom_addr !== 11'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_rom_addr: got %h expected %h", rom_addr, 11'd0);
    end
    tests_run++;
    if ({inst_valid, inst_pc, inst_data} !== {1'b0, 11'd0, 32'd0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got v=%b pc=%h d=%h expected v=0 pc=0 d=0", inst_valid, inst_pc, inst_data);
    end
    rsta_n = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) @(negedge clka);
      tests_run++;
      if (rom_addr !== ADDR_W'(c)) begin
        tests_failed++;
        $display("[TB] FAIL startup_rom_addr c%0d: got %h expected %h", c, rom_addr, ADDR_W'(c));
      end
      if (c < 2) exp_v = {1'b0, inst_pc, inst_data};
      else       exp_v = {1'b1, ADDR_W'(c - 2), rom_word(ADDR_W'(c - 2))};
      tests_run++;
      if (c < 2 ? (inst_valid !== 1'b0) : ({inst_valid, inst_pc, inst_data} !== exp_v)) begin
        tests_failed++;
        $display("[TB] FAIL startup_head c%0d: got v=%b pc=%h d=%h expected v=%b pc=%h d=%h", c,
                 inst_valid, inst_pc, inst_data, exp_v[ADDR_W+DATA_W], exp_v[ADDR_W+DATA_W-1:DATA_W], exp_v[DATA_W-1:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] ep;
    do_reset();
    for (int c = 1; c <= 14; c++) begin
      @(negedge clka);
      if (c >= 2) begin
        ep = (c <= 8) ? 11'd0 : ADDR_W'(c - 8);
        tests_run++;
        if ({inst_valid, inst_pc, inst_data} !== {1'b1, ep, rom_word(ep)}) begin
          tests_failed++;
          $display("[TB] FAIL backpressure_head c%0d: got v=%b pc=%h d=%h expected v=1 pc=%h d=%h", c,
                   inst_valid, inst_pc, inst_data, ep, rom_word(ep));
        end
      end
      if (c >= 2 && c <= 8) begin
        tests_run++;
        if (rom_addr !== 11'd2) begin
          tests_failed++;
          $display("[TB] FAIL backpressure_rom_addr c%0d: got %h expected %h", c, rom_addr, 11'd2);
        end
      end
      if (c == 2) inst_ready = 1'b0;
      if (c == 8) inst_ready = 1'b1;
    end
  endtask

  task automatic test_redirect();
    logic [ADDR_W-1:0] ep;
    do_reset();
    @(negedge clka);
    @(negedge clka);
    inst_ready = 1'b0;
    repeat (2) @(negedge clka);
    tests_run++;
    if ({inst_valid, inst_pc} !== {1'b1, 11'd0}) begin
      tests_failed++;
      $display("[TB] FAIL redirect_pre_head: got v=%b pc=%h expected v=1 pc=000", inst_valid, inst_pc);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 11'h3FF;
    inst_ready     = 1'b1;
    @(negedge clka);
    redirect_valid = 1'b0;
    tests_run++;
    if (rom_addr !== 11'h3FF) begin
      tests_failed++;
      $display("[TB] FAIL redirect_rom_addr: got %h expected %h", rom_addr, 11'h3FF);
    end
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clka);
      tests_run++;
      if (k <= 2) begin
        if (inst_valid !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL redirect_gap T+%0d: got v=%b pc=%h expected v=0", k, inst_valid, inst_pc);
        end
      end else begin
        ep = 11'h3FF + ADDR_W'(k - 3);
        if ({inst_valid, inst_pc, inst_data} !== {1'b1, ep, rom_word(ep)}) begin
          tests_failed++;
          $display("[TB] FAIL redirect_head T+%0d: got v=%b pc=%h d=%h expected v=1 pc=%h d=%h", k,
                   inst_valid, inst_pc, inst_data, ep, rom_word(ep));
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] ep;
    @(negedge clka);
    redirect_valid = 1'b1;
    redirect_pc    = 11'h7FE;
    @(negedge clka);
    redirect_valid = 1'b0;
    tests_run++;
    if (rom_addr !== 11'h7FE) begin
      tests_failed++;
      $display("[TB] FAIL wrap_rom_addr: got %h expected %h", rom_addr, 11'h7FE);
    end
    @(negedge clka);
    for (int k = 0; k < 4; k++) begin
      @(negedge clka);
      ep = 11'h7FE + ADDR_W'(k);
      tests_run++;
      if ({inst_valid, inst_pc, inst_data} !== {1'b1, ep, rom_word(ep)}) begin
        tests_failed++;
        $display("[TB] FAIL wrap_head k%0d: got v=%b pc=%h d=%h expected v=1 pc=%h d=%h", k,
                 inst_valid, inst_pc, inst_data, ep, rom_word(ep));
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clka);
    redirect_valid = 1'b1;
    redirect_pc    = 11'h100;
    @(negedge clka);
    redirect_pc    = 11'h200;
    @(negedge clka);
    redirect_valid = 1'b0;
    tests_run++;
    if ({rom_addr, inst_valid} !== {11'h200, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_redirect_addr: got addr=%h v=%b expected addr=200 v=0", rom_addr, inst_valid);
    end
    @(negedge clka);
    tests_run++;
    if (inst_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_redirect_gap: got v=%b expected v=0", inst_valid);
    end
    @(negedge clka);
    tests_run++;
    if ({inst_valid, inst_pc, inst_data} !== {1'b1, 11'h200, rom_word(11'h200)}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_redirect_head: got v=%b pc=%h d=%h expected v=1 pc=200 d=%h",
               inst_valid, inst_pc, inst_data, rom_word(11'h200));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (4) @(negedge clka);
    tests_run++;
    if (inst_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL async_pre_valid: got %b expected 1", inst_valid);
    end
    #2;
    rsta_n = 1'b0;
    #1;
    tests_run++;
    if ({inst_valid, rom_addr, inst_pc, inst_data} !== {1'b0, 11'd0, 11'd0, 32'd0}) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_state: got v=%b addr=%h pc=%h d=%h expected all zero",
               inst_valid, rom_addr, inst_pc, inst_data);
    end
    @(negedge clka);
    rsta_n = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) @(negedge clka);
      tests_run++;
      if (c < 2) begin
        if ({inst_valid, rom_addr} !== {1'b0, ADDR_W'(c)}) begin
          tests_failed++;
          $display("[TB] FAIL async_restart c%0d: got v=%b addr=%h expected v=0 addr=%h", c, inst_valid, rom_addr, ADDR_W'(c));
        end
      end else if ({inst_valid, inst_pc, inst_data} !== {1'b1, ADDR_W'(c - 2), rom_word(ADDR_W'(c - 2))}) begin
        tests_failed++;
        $display("[TB] FAIL async_restart c%0d: got v=%b pc=%h d=%h expected v=1 pc=%h", c,
                 inst_valid, inst_pc, inst_data, ADDR_W'(c - 2));
      end
    end
  endtask

`ifdef INSTR_FETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    tests_run++;
    if ({perf_fetched, perf_stall} !== 64'd0) begin
      tests_failed++;
      $display("[TB] FAIL perf_reset: got f=%0d s=%0d expected 0 0", perf_fetched, perf_stall);
    end
    for (int c = 1; c <= 15; c++) begin
      @(negedge clka);
      if (c == 11) begin
        redirect_valid = 1'b1;
        redirect_pc    = 11'h020;
      end
      if (c == 12) begin
        tests_run++;
        if ({perf_fetched, perf_stall} !== {32'd10, 32'd2}) begin
          tests_failed++;
          $display("[TB] FAIL perf_full_rate: got f=%0d s=%0d expected f=10 s=2", perf_fetched, perf_stall);
        end
        redirect_pc = 11'h030;
      end
      if (c == 13) redirect_valid = 1'b0;
      if (c >= 12 && c <= 14) begin
        tests_run++;
        if (inst_valid !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL perf_gap c%0d: got v=%b expected v=0", c, inst_valid);
        end
      end
      if (c == 15) begin
        tests_run++;
        if ({perf_fetched, perf_stall, inst_valid, inst_pc} !== {32'd11, 32'd5, 1'b1, 11'h030}) begin
          tests_failed++;
          $display("[TB] FAIL perf_after_gap: got f=%0d s=%0d v=%b pc=%h expected f=11 s=5 v=1 pc=030",
                   perf_fetched, perf_stall, inst_valid, inst_pc);
        end
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rsta_n         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    test_reset();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_back_to_back();
    test_async_reset();
`ifdef INSTR_FETCH_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
